mux_stage_nx1: RTL and testbench

Parametrised N-way select pipeline stage for the datapath: picks one of CHANNELS input words by a binary select, registers the result, and passes it downstream over a valid/ready handshake through a 2-entry skid buffer. Used wherever a result mux feeds a pipeline boundary, for example writeback source selection, so that the select path is timing-isolated and back-pressure is absorbed without a combinational ready path. Out-of-range selects resolve to the highest channel and are flagged per beat.

---
 rtl/mux_stage_nx1.sv | 66 ++++++
 tb/tb_mux_stage_nx1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_stage_nx1.sv
// mux_stage_nx1: N-way select into a registered 2-entry skid buffer with valid/ready handshake
module mux_stage_nx1 #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 5,
  parameter int SEL_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_clamped,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush
);
  localparam int BW = WIDTH + SEL_W + 1;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [WIDTH-1:0] ch [CHANNELS];
  logic [BW-1:0] main_q, skid_q, beat;
  logic [SEL_W-1:0] idx;
  logic clamped, accept;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = in_data[k*WIDTH +: WIDTH];
  end
  always_comb begin
    idx = (in_sel >= SEL_W'(CHANNELS - 1)) ? SEL_W'(CHANNELS - 1) : in_sel;
    clamped = {1'b0, in_sel} >= (SEL_W + 1)'(CHANNELS);
    beat = {clamped, idx, ch[idx]};
  end
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept = in_valid && in_ready;
  assign {out_clamped, out_sel, out_data} = main_q;
  // main always holds the oldest beat; skid only fills when main is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q <= beat;
          state <= ONE;
        end
        ONE: if (accept && out_ready) main_q <= beat;
        else if (accept) begin
          skid_q <= beat;
          state <= FULL;
        end else if (out_ready) state <= EMPTY;
        FULL: if (out_ready) begin
          main_q <= skid_q;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_stage_nx1.sv
// tb_mux_stage_nx1: directed and scoreboard checks of the select/skid stage
module tb_mux_stage_nx1;
  logic clk = 0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, out_clamped;
  logic [159:0] in_data;
  logic [2:0] in_sel, out_sel;
  logic [31:0] out_data, want;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mux_stage_nx1 #(.WIDTH(32), .CHANNELS(5), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_clamped(out_clamped),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_sel = 0;
    step();
    step();
    total++;
    if ({out_valid, in_ready, out_data, out_sel, out_clamped} !== {1'b0, 1'b1, 32'h0, 3'h0, 1'b0})
      $display("FAIL reset: got v=%b r=%b d=%h s=%0d c=%b, want 0 1 0 0 0", out_valid, in_ready, out_data, out_sel, out_clamped);
    else passed++;
    rst = 0;
  endtask
  task automatic test_select();
    out_ready = 1; in_valid = 1;
    for (int s = 0; s < 5; s++) begin
      in_sel = 3'(s);
      step();
      want = 32'hA0000000 + s;
      total++;
      if (out_valid !== 1 || out_data !== want || out_sel !== 3'(s) || out_clamped !== 0)
        $display("FAIL select%0d: got v=%b d=%h s=%0d c=%b, want 1 %h %0d 0", s, out_valid, out_data, out_sel, out_clamped, want, s);
      else passed++;
    end
    in_valid = 0;
    step();
    total++;
    if (out_valid !== 0) $display("FAIL select_drain: got out_valid=%b, want 0", out_valid);
    else passed++;
  endtask
  task automatic test_clamp();
    out_ready = 1; in_valid = 1;
    for (int s = 5; s < 8; s++) begin
      in_sel = 3'(s);
      step();
      total++;
      if (out_valid !== 1 || out_data !== 32'hA0000004 || out_sel !== 3'd4 || out_clamped !== 1)
        $display("FAIL clamp%0d: got v=%b d=%h s=%0d c=%b, want 1 a0000004 4 1", s, out_valid, out_data, out_sel, out_clamped);
      else passed++;
    end
    in_valid = 0;
    step();
  endtask
  task automatic test_stall();
    in_valid = 1; out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      in_sel = 3'(c + 1);
      step();
      total++;
      if (out_valid !== 1 || out_data !== 32'hA0000001 || out_sel !== 3'd1 || in_ready !== (c == 0))
        $display("FAIL stall%0d: got v=%b d=%h s=%0d r=%b, want 1 a0000001 1 %b", c, out_valid, out_data, out_sel, in_ready, c == 0);
      else passed++;
    end
    in_valid = 0; out_ready = 1;
    step();
    total++;
    if (out_valid !== 1 || out_data !== 32'hA0000002 || in_ready !== 1)
      $display("FAIL stall_release: got v=%b d=%h r=%b, want 1 a0000002 1", out_valid, out_data, in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 0) $display("FAIL stall_drain: got out_valid=%b, want 0", out_valid);
    else passed++;
  endtask
  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_sel = 0;
    step();
    in_sel = 1;
    step();
    total++;
    if (in_ready !== 0 || out_valid !== 1 || out_data !== 32'hA0000000)
      $display("FAIL flush_fill: got r=%b v=%b d=%h, want 0 1 a0000000", in_ready, out_valid, out_data);
    else passed++;
    flush = 1; in_sel = 2;
    step();
    flush = 0; in_valid = 0;
    total++;
    if (out_valid !== 0 || in_ready !== 1) $display("FAIL flush_full: got v=%b r=%b, want 0 1", out_valid, in_ready);
    else passed++;
    out_ready = 1;
    step();
    total++;
    if (out_valid !== 0) $display("FAIL flush_full_stale: got out_valid=%b, want 0", out_valid);
    else passed++;
    out_ready = 0; in_valid = 1; in_sel = 3;
    step();
    flush = 1; in_sel = 4;
    step();
    flush = 0; in_valid = 0;
    total++;
    if (out_valid !== 0 || in_ready !== 1) $display("FAIL flush_one: got v=%b r=%b, want 0 1", out_valid, in_ready);
    else passed++;
    out_ready = 1;
    step();
    total++;
    if (out_valid !== 0) $display("FAIL flush_one_stale: got out_valid=%b, want 0", out_valid);
    else passed++;
    in_valid = 1; in_sel = 1;
    step();
    in_valid = 0;
    total++;
    if (out_valid !== 1 || out_data !== 32'hA0000001 || out_sel !== 3'd1)
      $display("FAIL flush_resume: got v=%b d=%h s=%0d, want 1 a0000001 1", out_valid, out_data, out_sel);
    else passed++;
    step();
    total++;
    if (out_valid !== 0) $display("FAIL flush_resume_drain: got out_valid=%b, want 0", out_valid);
    else passed++;
  endtask
  task automatic test_rst_resume();
    out_ready = 0; in_valid = 1; in_sel = 2;
    step();
    rst = 1; flush = 1; in_sel = 3;
    step();
    rst = 0; flush = 0;
    total++;
    if (out_valid !== 0 || in_ready !== 1) $display("FAIL rst_flush: got v=%b r=%b, want 0 1", out_valid, in_ready);
    else passed++;
    out_ready = 1; in_sel = 4;
    step();
    total++;
    if (out_valid !== 1 || out_data !== 32'hA0000004 || out_sel !== 3'd4 || out_clamped !== 0)
      $display("FAIL rst_resume: got v=%b d=%h s=%0d c=%b, want 1 a0000004 4 0", out_valid, out_data, out_sel, out_clamped);
    else passed++;
    out_ready = 0; in_sel = 0;
    step();
    in_sel = 1;
    step();
    rst = 1;
    step();
    rst = 0; in_valid = 0;
    total++;
    if (out_valid !== 0 || in_ready !== 1) $display("FAIL rst_mid: got v=%b r=%b, want 0 1", out_valid, in_ready);
    else passed++;
    out_ready = 1;
    step();
    total++;
    if (out_valid !== 0) $display("FAIL rst_mid_stale: got out_valid=%b, want 0", out_valid);
    else passed++;
    in_valid = 1; in_sel = 6;
    step();
    in_valid = 0;
    total++;
    if (out_valid !== 1 || out_data !== 32'hA0000004 || out_sel !== 3'd4 || out_clamped !== 1)
      $display("FAIL rst_mid_resume: got v=%b d=%h s=%0d c=%b, want 1 a0000004 4 1", out_valid, out_data, out_sel, out_clamped);
    else passed++;
    step();
  endtask
  task automatic test_random();
    logic [35:0] q[$];
    int n_acc = 0;
    int c = 0;
    int idx;
    while ((n_acc < 1000 || q.size() != 0) && c < 20000) begin
      @(negedge clk);
      c++;
      for (int k = 0; k < 5; k++) in_data[k*32 +: 32] = $urandom;
      in_sel = 3'($urandom_range(7));
      in_valid = (n_acc < 1000) && ($urandom_range(1) == 1);
      out_ready = $urandom_range(1) == 1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0 || {out_clamped, out_sel, out_data} !== q[0])
          $display("FAIL random_beat: got c=%b s=%0d d=%h, want %h (queue %0d)", out_clamped, out_sel, out_data, q.size() ? q[0] : 36'h0, q.size());
        else passed++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        idx = in_sel >= 4 ? 4 : int'(in_sel);
        q.push_back({in_sel >= 3'd5, 3'(idx), in_data[idx*32 +: 32]});
        n_acc++;
      end
    end
    in_valid = 0; out_ready = 1;
    total++;
    if (n_acc != 1000 || q.size() != 0)
      $display("FAIL random_done: got accepted=%0d left=%0d, want 1000 0", n_acc, q.size());
    else passed++;
  endtask
  initial begin
    for (int k = 0; k < 5; k++) in_data[k*32 +: 32] = 32'hA0000000 + k;
    test_reset();
    test_select();
    test_clamp();
    test_stall();
    test_flush();
    test_rst_resume();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
